pc_update: RTL and testbench
============================

// Module: pc_update
// PURPOSE
//  Y86-64 PC-update / status stage: drives the pc consumed by fetch. On each retiring instruction
//  selects next pc from fetch/execute/memory results (valP, valC, valM, cnd), tracks the sticky
//  processor status (AOK/HLT/ADR/INS) and freezes the machine on halt or fault. Sits at the
//  end of the SEQ datapath, closing the loop back to fetch.
// PARAMETERS
//  RESET_PC   64'd0      pc loaded on reset
//  MAX_CYCLES 64'd10000  watchdog limit on advances while running; 0 disables
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  advance      in   1   current instruction completed all stages; sample inputs this edge
//  icode        in   4   instruction code from fetch
//  cnd          in   1   condition result from execute (jXX)
//  valC         in   64  constant/target from fetch
//  valP         in   64  fall-through address from fetch
//  valM         in   64  value read from data memory (ret target)
//  halt         in   1   fetch decoded halt
//  instr_valid  in   1   fetch decoded a legal icode/ifun
//  imem_error   in   1   fetch address out of range
//  dmem_error   in   1   data-memory address out of range
//  pc           out  64  address of instruction to fetch
//  stat         out  3   1=AOK 2=HLT 3=ADR 4=INS
//  running      out  1   high while stat==AOK and watchdog not expired
//  retired      out  64  count of instructions retired with AOK
//  timeout      out  1   sticky: watchdog expired
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-run): pc=RESET_PC, stat=AOK, running=1, retired=0,
//    timeout=0, watchdog count=0. All outputs registered.
//  - States: RUN (stat AOK) and STOP (stat != AOK or timeout). STOP exits only via rst.
//  - In RUN, on posedge with advance=1, new status by priority:
//    imem_error|dmem_error -> ADR; else !instr_valid -> INS; else halt -> HLT; else AOK.
//  - New status AOK: pc<=next_pc, retired<=retired+1, stay RUN.
//  - New status non-AOK: stat<=code, pc holds (points at offending instr), retired holds,
//    running<=0, go STOP.
//  - next_pc: call(8)->valC; jXX(7)&cnd->valC; jXX&!cnd->valP; ret(9)->valM; else valP.
//  - Latency: new pc visible one cycle after the advance edge; advance=0 holds all state.
//  - advance in STOP ignored; inputs are don't-care.
//  - Watchdog: count advances in RUN; when count reaches MAX_CYCLES (MAX_CYCLES!=0), that
//    edge sets timeout=1, running=0, stat stays AOK, pc/retired not updated.
//    Simultaneous fault+expiry: fault stat recorded and timeout set.
//  - Arithmetic: 64-bit unsigned, retired and watchdog wrap modulo 2^64; no pc alignment check.
// STRUCTURE
//  - Shared package y86_pkg: icode constants (IHALT..IPOPQ = 0..B), stat codes
//    (SAOK=1,SHLT=2,SADR=3,SINS=4), 64-bit word typedef; fetch and this block import it.
//  - One sub-module pc_select: pure combinational next_pc mux (icode,cnd,valC,valP,valM).
//  - Top holds pc/stat/retired/watchdog registers and the RUN/STOP control.
// TESTING
//  1 rst high mid-run, release -> pc=0, stat=1, running=1, retired=0 within same cycle of assert.
//  2 advance, icode=3 valP=0x0A -> next cycle pc=0x0A, retired=1; advance=0 three cycles -> no change.
//  3 icode=7 cnd=1 valC=0x40 -> pc=0x40; icode=7 cnd=0 valP=0x49 -> pc=0x49;
//    icode=8 valC=0x100 -> pc=0x100; icode=9 valM=0x13 -> pc=0x13.
//  4 pc=0x20, advance with halt=1 -> stat=2, running=0, pc=0x20; further advances ignored.
//  5 imem_error=1 with instr_valid=0 -> stat=3 (ADR wins); after rst, instr_valid=0 -> stat=4.
//  6 MAX_CYCLES=3, four AOK advances -> retired=2, timeout=1, running=0, stat=1, pc frozen.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, processor status codes,
// the 64-bit machine word and the PC-update control states.
package y86_pkg;

    typedef logic [63:0] word_t;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // PC-update control: RUN while the machine makes progress, STOP once
    // a fault, halt or watchdog expiry has frozen it (only reset leaves STOP).
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } pc_state_e;

    // Status of the retiring instruction. Address errors outrank an
    // illegal instruction, which outranks a decoded halt.
    function automatic logic [2:0] retire_status(
        input logic imem_error,
        input logic dmem_error,
        input logic instr_valid,
        input logic halt
    );
        logic [2:0] code;
        if (imem_error || dmem_error) begin
            code = SADR;
        end else if (!instr_valid) begin
            code = SINS;
        end else if (halt) begin
            code = SHLT;
        end else begin
            code = SAOK;
        end
        return code;
    endfunction

endpackage

// File: rtl/pc_update_if.sv
// Bundle between the SEQ datapath (fetch/execute/memory results) and the
// PC-update stage.
//
// Handshake: there is no ready. When advance is high at a rising clock edge
// the stage samples every other input field on that edge; when advance is
// low the fields are ignored. The outputs are registered and change only on
// an advance edge (or on reset), one cycle after the sampled edge.
interface pc_update_if;
    import y86_pkg::*;

    logic       advance;
    logic [3:0] icode;
    logic       cnd;
    word_t      valC;
    word_t      valP;
    word_t      valM;
    logic       halt;
    logic       instr_valid;
    logic       imem_error;
    logic       dmem_error;

    word_t      pc;
    logic [2:0] stat;
    logic       running;
    word_t      retired;
    logic       timeout;

    // Datapath side: supplies instruction results, consumes pc/status
    modport master (
        output advance, icode, cnd, valC, valP, valM,
        output halt, instr_valid, imem_error, dmem_error,
        input  pc, stat, running, retired, timeout
    );

    // PC-update stage side
    modport slave (
        input  advance, icode, cnd, valC, valP, valM,
        input  halt, instr_valid, imem_error, dmem_error,
        output pc, stat, running, retired, timeout
    );

endinterface

// File: rtl/pc_update_pc_select.sv
// Next-pc selection for a retiring instruction: call and taken jumps go to
// valC, ret goes to the popped return address valM, everything else falls
// through to valP.
module pc_select
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  word_t      valC,
    input  word_t      valP,
    input  word_t      valM,
    output word_t      next_pc
);

    // Pure combinational mux on the instruction class
    always_comb begin
        next_pc = valP;
        case (icode)
            ICALL:   next_pc = valC;
            IJXX:    next_pc = cnd ? valC : valP;
            IRET:    next_pc = valM;
            default: next_pc = valP;
        endcase
    end

endmodule

// File: rtl/pc_update.sv
// Y86-64 PC-update / status stage. Holds the architectural pc, the sticky
// processor status, the retired-instruction counter and a watchdog that
// stops a runaway program after MAX_CYCLES advances (0 disables it).
module pc_update
    import y86_pkg::*;
#(
    parameter word_t RESET_PC   = 64'd0,
    parameter word_t MAX_CYCLES = 64'd10000
) (
    input  logic        clk,
    input  logic        rst,
    pc_update_if.slave  bus,
    output pc_state_e   dbg_state
);

    pc_state_e  state;
    word_t      pc_q;
    logic [2:0] stat_q;
    logic       running_q;
    word_t      retired_q;
    logic       timeout_q;
    word_t      wd_count;

    word_t      next_pc;
    logic [2:0] new_stat;
    word_t      wd_next;
    logic       wd_expire;

    pc_select u_pc_select (
        .icode   (bus.icode),
        .cnd     (bus.cnd),
        .valC    (bus.valC),
        .valP    (bus.valP),
        .valM    (bus.valM),
        .next_pc (next_pc)
    );

    // Status of the instruction retiring on this edge and watchdog lookahead
    always_comb begin
        new_stat  = retire_status(bus.imem_error, bus.dmem_error,
                                  bus.instr_valid, bus.halt);
        wd_next   = wd_count + 64'd1;
        wd_expire = (MAX_CYCLES != 64'd0) && (wd_next == MAX_CYCLES);
    end

    // RUN/STOP control with registered pc, status, counters and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            pc_q      <= RESET_PC;
            stat_q    <= SAOK;
            running_q <= 1'b1;
            retired_q <= 64'd0;
            timeout_q <= 1'b0;
            wd_count  <= 64'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.advance) begin
                        wd_count <= wd_next;
                        if (wd_expire) begin
                            // Expiry freezes pc/retired; a fault on the
                            // same edge still records its status.
                            timeout_q <= 1'b1;
                            running_q <= 1'b0;
                            state     <= ST_STOP;
                            if (new_stat != SAOK) begin
                                stat_q <= new_stat;
                            end
                        end else if (new_stat != SAOK) begin
                            // pc stays on the offending instruction
                            stat_q    <= new_stat;
                            running_q <= 1'b0;
                            state     <= ST_STOP;
                        end else begin
                            pc_q      <= next_pc;
                            retired_q <= retired_q + 64'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Frozen until reset; advance and inputs are ignored
                end
                default: begin
                    state <= ST_STOP;
                end
            endcase
        end
    end

    assign bus.pc      = pc_q;
    assign bus.stat    = stat_q;
    assign bus.running = running_q;
    assign bus.retired = retired_q;
    assign bus.timeout = timeout_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: two instances share one directed stimulus stream,
// one with the default watchdog and one with MAX_CYCLES=3. A reference
// model of the architectural rules is stepped on every clock edge and
// compared against both instances on every falling edge; literal
// expectations pin the model at key points.
module tb_pc_update;
    import y86_pkg::*;

    localparam word_t MAX_A = 64'd10000;
    localparam word_t MAX_B = 64'd3;

    logic      clk;
    logic      rst;
    pc_state_e st_a;
    pc_state_e st_b;

    int n_checks;
    int n_errors;

    pc_update_if bus_a ();
    pc_update_if bus_b ();

    pc_update #(.RESET_PC(64'd0), .MAX_CYCLES(MAX_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a.slave),
        .dbg_state (st_a)
    );

    pc_update #(.RESET_PC(64'd0), .MAX_CYCLES(MAX_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b.slave),
        .dbg_state (st_b)
    );

    // Both instances see identical inputs
    assign bus_b.advance     = bus_a.advance;
    assign bus_b.icode       = bus_a.icode;
    assign bus_b.cnd         = bus_a.cnd;
    assign bus_b.valC        = bus_a.valC;
    assign bus_b.valP        = bus_a.valP;
    assign bus_b.valM        = bus_a.valM;
    assign bus_b.halt        = bus_a.halt;
    assign bus_b.instr_valid = bus_a.instr_valid;
    assign bus_b.imem_error  = bus_a.imem_error;
    assign bus_b.dmem_error  = bus_a.dmem_error;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    word_t      m_pc      [2];
    logic [2:0] m_stat    [2];
    logic       m_timeout [2];
    word_t      m_retired [2];
    word_t      m_adv     [2];

    function automatic logic m_stopped(input int d);
        return (m_stat[d] != 3'd1) || m_timeout[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d]      = 64'd0;
            m_stat[d]    = 3'd1;
            m_timeout[d] = 1'b0;
            m_retired[d] = 64'd0;
            m_adv[d]     = 64'd0;
        end
    endtask

    task automatic model_step(input int d, input word_t limit);
        logic [2:0] code;
        word_t      target;
        if (m_stopped(d) || !bus_a.advance) return;
        if (bus_a.imem_error || bus_a.dmem_error) code = 3'd3;
        else if (!bus_a.instr_valid)              code = 3'd4;
        else if (bus_a.halt)                      code = 3'd2;
        else                                      code = 3'd1;
        if (bus_a.icode == 4'd8)                    target = bus_a.valC;
        else if (bus_a.icode == 4'd7 && bus_a.cnd)  target = bus_a.valC;
        else if (bus_a.icode == 4'd9)               target = bus_a.valM;
        else                                        target = bus_a.valP;
        m_adv[d] = m_adv[d] + 64'd1;
        if (limit != 64'd0 && m_adv[d] == limit) begin
            m_timeout[d] = 1'b1;
            m_stat[d]    = code;
        end else if (code != 3'd1) begin
            m_stat[d] = code;
        end else begin
            m_pc[d]      = target;
            m_retired[d] = m_retired[d] + 64'd1;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int d, input string tag, input word_t pc,
                               input logic [2:0] stat, input logic running,
                               input word_t retired, input logic timeout);
        check({tag, ".pc"},      pc,      m_pc[d]);
        check({tag, ".stat"},    {61'd0, stat},    {61'd0, m_stat[d]});
        check({tag, ".running"}, {63'd0, running}, {63'd0, !m_stopped(d)});
        check({tag, ".retired"}, retired, m_retired[d]);
        check({tag, ".timeout"}, {63'd0, timeout}, {63'd0, m_timeout[d]});
    endtask

    // Compare process: outputs are registered, so every falling edge
    // outside reset is a meaningful sample point.
    always @(negedge clk) begin
        if (!rst) begin
            compare_dut(0, "a", bus_a.pc, bus_a.stat, bus_a.running, bus_a.retired, bus_a.timeout);
            compare_dut(1, "b", bus_b.pc, bus_b.stat, bus_b.running, bus_b.retired, bus_b.timeout);
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a falling edge; drives one clock of stimulus.
    task automatic drive(input logic adv, input logic [3:0] icode, input logic cnd,
                         input word_t vc, input word_t vp, input word_t vm,
                         input logic halt, input logic valid,
                         input logic imem, input logic dmem);
        bus_a.advance     = adv;
        bus_a.icode       = icode;
        bus_a.cnd         = cnd;
        bus_a.valC        = vc;
        bus_a.valP        = vp;
        bus_a.valM        = vm;
        bus_a.halt        = halt;
        bus_a.instr_valid = valid;
        bus_a.imem_error  = imem;
        bus_a.dmem_error  = dmem;
        @(posedge clk);
        model_step(0, MAX_A);
        model_step(1, MAX_B);
        @(negedge clk);
        #1;
    endtask

    task automatic aok(input logic [3:0] icode, input logic cnd,
                       input word_t vc, input word_t vp, input word_t vm);
        drive(1'b1, icode, cnd, vc, vp, vm, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'd3, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        bus_a.advance     = 1'b0;
        bus_a.icode       = 4'd0;
        bus_a.cnd         = 1'b0;
        bus_a.valC        = 64'd0;
        bus_a.valP        = 64'd0;
        bus_a.valM        = 64'd0;
        bus_a.halt        = 1'b0;
        bus_a.instr_valid = 1'b1;
        bus_a.imem_error  = 1'b0;
        bus_a.dmem_error  = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pc", bus_a.pc, 64'd0);
        check("reset_stat", {61'd0, bus_a.stat}, 64'd1);

        // 1: reset asserted mid-cycle after some progress
        aok(4'd3, 1'b0, 64'h0, 64'h10, 64'h0);
        aok(4'd3, 1'b0, 64'h0, 64'h20, 64'h0);
        check("pre_rst_pc", bus_a.pc, 64'h20);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_pc", bus_a.pc, 64'd0);
        check("midrst_stat", {61'd0, bus_a.stat}, 64'd1);
        check("midrst_running", {63'd0, bus_a.running}, 64'd1);
        check("midrst_retired", bus_a.retired, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 2: fall-through then hold with advance low
        aok(4'd3, 1'b0, 64'h0, 64'h0A, 64'h0);
        check("irmovq_pc", bus_a.pc, 64'h0A);
        check("irmovq_retired", bus_a.retired, 64'd1);
        idle(3);
        check("hold_pc", bus_a.pc, 64'h0A);
        check("hold_retired", bus_a.retired, 64'd1);

        // 3: control flow selection
        aok(4'd7, 1'b1, 64'h40, 64'h13, 64'h0);
        check("jxx_taken_pc", bus_a.pc, 64'h40);
        aok(4'd7, 1'b0, 64'h999, 64'h49, 64'h0);
        check("jxx_nottaken_pc", bus_a.pc, 64'h49);
        check("b_timeout_after3", {63'd0, bus_b.timeout}, 64'd1);
        aok(4'd8, 1'b0, 64'h100, 64'h52, 64'h0);
        check("call_pc", bus_a.pc, 64'h100);
        aok(4'd9, 1'b0, 64'h777, 64'h101, 64'h13);
        check("ret_pc", bus_a.pc, 64'h13);
        check("ret_retired", bus_a.retired, 64'd5);

        // 4: halt freezes pc and ignores later advances
        aok(4'd3, 1'b0, 64'h0, 64'h20, 64'h0);
        drive(1'b1, 4'd0, 1'b0, 64'h0, 64'h21, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("halt_stat", {61'd0, bus_a.stat}, 64'd2);
        check("halt_running", {63'd0, bus_a.running}, 64'd0);
        check("halt_pc", bus_a.pc, 64'h20);
        aok(4'd3, 1'b0, 64'h0, 64'h77, 64'h0);
        aok(4'd8, 1'b0, 64'h88, 64'h77, 64'h0);
        check("halt_frozen_pc", bus_a.pc, 64'h20);
        check("halt_frozen_retired", bus_a.retired, 64'd6);

        // 5: status priority
        do_reset();
        drive(1'b1, 4'd3, 1'b0, 64'h0, 64'h0A, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("adr_over_ins", {61'd0, bus_a.stat}, 64'd3);
        check("adr_pc", bus_a.pc, 64'd0);
        do_reset();
        drive(1'b1, 4'd3, 1'b0, 64'h0, 64'h0A, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ins_over_hlt", {61'd0, bus_a.stat}, 64'd4);
        do_reset();
        aok(4'd3, 1'b0, 64'h0, 64'h0A, 64'h0);
        drive(1'b1, 4'd5, 1'b0, 64'h0, 64'h14, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("dmem_adr", {61'd0, bus_a.stat}, 64'd3);
        check("dmem_pc", bus_a.pc, 64'h0A);

        // 6: watchdog expiry on the MAX_CYCLES=3 instance
        do_reset();
        aok(4'd3, 1'b0, 64'h0, 64'h08, 64'h0);
        aok(4'd3, 1'b0, 64'h0, 64'h10, 64'h0);
        aok(4'd3, 1'b0, 64'h0, 64'h18, 64'h0);
        aok(4'd3, 1'b0, 64'h0, 64'h20, 64'h0);
        check("wd_retired", bus_b.retired, 64'd2);
        check("wd_timeout", {63'd0, bus_b.timeout}, 64'd1);
        check("wd_running", {63'd0, bus_b.running}, 64'd0);
        check("wd_stat", {61'd0, bus_b.stat}, 64'd1);
        check("wd_pc", bus_b.pc, 64'h10);
        check("nowd_retired", bus_a.retired, 64'd4);

        // Fault on the same edge as expiry
        do_reset();
        aok(4'd3, 1'b0, 64'h0, 64'h30, 64'h0);
        aok(4'd3, 1'b0, 64'h0, 64'h38, 64'h0);
        drive(1'b1, 4'd0, 1'b0, 64'h0, 64'h39, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("wd_fault_stat", {61'd0, bus_b.stat}, 64'd2);
        check("wd_fault_timeout", {63'd0, bus_b.timeout}, 64'd1);
        check("wd_fault_pc", bus_b.pc, 64'h38);
        check("nowd_fault_timeout", {63'd0, bus_a.timeout}, 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
